// File: rtl/sync_to_async_tx.sv
// sync_to_async_tx
//   Clocked producer for a 4-phase bundled-data asynchronous channel.
//   Words arrive on a valid/ready interface, are buffered in a small FIFO,
//   and each is played out as one complete r_o/a_i handshake with d_o held
//   stable from before the request rises until the acknowledge has returned low.
//   The returning acknowledge is brought into clk through a flop synchroniser.
//
// Parameters
//   N            data width of in_data and d_o
//   DEPTH        FIFO entries (power of 2, >= 2)
//   SYNC_STAGES  flops in the a_i synchroniser (>= 2)
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   in_valid  in   producer has a word on in_data
//   in_ready  out  FIFO can accept (transfer on in_valid & in_ready at posedge clk)
//   in_data   in   word to send
//   r_o       out  asynchronous request, registered
//   a_i       in   asynchronous acknowledge from the receiver
//   d_o       out  bundled data, registered
//   level     out  FIFO occupancy
//   busy      out  handshake FSM not idle
module sync_to_async_tx #(
    parameter int unsigned N           = 6,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_data,
    output logic                       r_o,
    input  logic                       a_i,
    output logic [N-1:0]               d_o,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic                   r_nx;
    logic                   pop;
    logic                   push;
    logic                   ready_en;
    logic                   ack_s;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [N-1:0]           mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [LW-1:0]          count;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // ready_en keeps in_ready low during reset and rises on the first edge
    // after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign in_ready = ready_en && (count != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign level    = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // DEPTH is a power of 2, so the pointers wrap naturally at AW bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Acknowledge synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r_o   <= 1'b0;
        end else begin
            state <= state_nx;
            r_o   <= r_nx;
        end
    end

    // Loading d_o is tied to the pop, so data only changes on entry to SETUP
    // and a full SETUP cycle with r_o low always precedes the request.
    always_comb begin
        state_nx = state;
        r_nx     = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = SETUP;
                    pop      = 1'b1;
                end
            end
            SETUP: begin
                // Receiver may still be holding its ack high; wait it out.
                if (!ack_s) begin
                    state_nx = REQ_HI;
                    r_nx     = 1'b1;
                end
            end
            REQ_HI: begin
                r_nx = 1'b1;
                if (ack_s) begin
                    state_nx = REQ_LO;
                    r_nx     = 1'b0;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    if (count != '0) begin
                        state_nx = SETUP;
                        pop      = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_o <= '0;
        end else if (pop) begin
            d_o <= mem[rd_ptr];
        end
    end

    assign busy = (state != IDLE);

endmodule
